eq_band_gain_ctrl: RTL and testbench

//  Configuration sequencer for the 8-band Equalizer gain/enable inputs (amp_coef_N, ena_N).
//  - A host writes per-band target gain/enable into shadow registers over a valid/ready port.
//  - A commit request applies the targets click-free: gains step by 1 LSB per audio sample

---
 rtl/eq_band_gain_ctrl.sv | 135 +++++++++++++
 tb/tb_eq_band_gain_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eq_band_gain_ctrl.sv
// Click-free gain/enable sequencer for the 8-band equalizer coefficient ports.
// Host writes shadow targets; a commit ramps active gains 1 LSB per sample tick.
module eq_band_gain_ctrl #(
   parameter int                   NUM_BANDS  = 8,
   parameter int                   GAIN_W     = 3,
   parameter logic [GAIN_W-1:0]    RESET_GAIN = 'd1,
   parameter logic [NUM_BANDS-1:0] RESET_ENA  = {NUM_BANDS{1'b1}}
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          sample_tick,
   input  logic                          cfg_valid,
   output logic                          cfg_ready,
   input  logic [2:0]                    cfg_band,
   input  logic [GAIN_W-1:0]             cfg_gain,
   input  logic                          cfg_ena,
   input  logic                          commit,
   output logic                          busy,
   output logic                          done,
   output logic [NUM_BANDS-1:0]          ena_out,
   output logic [NUM_BANDS*GAIN_W-1:0]   amp_coef_out
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RAMP
   } state_e;

   typedef logic [NUM_BANDS-1:0][GAIN_W-1:0] gains_t;

   state_e               state_q, state_d;
   gains_t               sh_gain_q, sh_gain_d;
   logic [NUM_BANDS-1:0] sh_ena_q, sh_ena_d;
   gains_t               gain_q, gain_d;
   logic [NUM_BANDS-1:0] ena_q, ena_d;
   logic                 done_q, done_d;

   gains_t               tgt_gain;
   gains_t               gain_step;
   logic [NUM_BANDS-1:0] ena_step;
   logic                 need_step;
   logic                 wr;

   assign cfg_ready    = (state_q == S_IDLE);
   assign busy         = (state_q != S_IDLE);
   assign done         = done_q;
   assign ena_out      = ena_q;
   assign amp_coef_out = gain_q;
   assign wr           = cfg_valid & cfg_ready;

   always_comb begin
      sh_gain_d = sh_gain_q;
      sh_ena_d  = sh_ena_q;
      if (wr) begin
         sh_gain_d[cfg_band] = cfg_gain;
         sh_ena_d[cfg_band]  = cfg_ena;
      end
   end

   // A disabled target ramps to zero before its enable is dropped.
   always_comb begin
      tgt_gain = '0;
      for (int b = 0; b < NUM_BANDS; b++) begin
         tgt_gain[b] = sh_ena_q[b] ? sh_gain_q[b] : '0;
      end
   end

   always_comb begin
      gain_step = gain_q;
      ena_step  = ena_q;
      need_step = 1'b0;
      for (int b = 0; b < NUM_BANDS; b++) begin
         if (sh_ena_q[b] && !ena_q[b]) begin
            ena_step[b] = 1'b1;
            need_step   = 1'b1;
         end else if (gain_q[b] < tgt_gain[b]) begin
            gain_step[b] = gain_q[b] + 1'b1;
            need_step    = 1'b1;
         end else if (gain_q[b] > tgt_gain[b]) begin
            gain_step[b] = gain_q[b] - 1'b1;
            need_step    = 1'b1;
         end else if (!sh_ena_q[b] && ena_q[b]) begin
            ena_step[b] = 1'b0;
            need_step   = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      gain_d  = gain_q;
      ena_d   = ena_q;
      done_d  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (commit) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (sample_tick) state_d = S_RAMP;
         end
         S_RAMP: begin
            if (sample_tick) begin
               if (need_step) begin
                  gain_d = gain_step;
                  ena_d  = ena_step;
               end else begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         sh_gain_q <= {NUM_BANDS{RESET_GAIN}};
         sh_ena_q  <= RESET_ENA;
         gain_q    <= {NUM_BANDS{RESET_GAIN}};
         ena_q     <= RESET_ENA;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         sh_gain_q <= sh_gain_d;
         sh_ena_q  <= sh_ena_d;
         gain_q    <= gain_d;
         ena_q     <= ena_d;
         done_q    <= done_d;
      end
   end

endmodule

// File: tb/tb_eq_band_gain_ctrl.sv
// Bench for eq_band_gain_ctrl: closed-form ramp model checked every cycle
// plus directed scenarios with literal expectations.
module tb_eq_band_gain_ctrl;

   localparam int NB = 8;
   localparam int GW = 3;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            sample_tick = 1'b0;
   logic            cfg_valid = 1'b0;
   logic            cfg_ready;
   logic [2:0]      cfg_band = '0;
   logic [GW-1:0]   cfg_gain = '0;
   logic            cfg_ena = 1'b0;
   logic            commit = 1'b0;
   logic            busy;
   logic            done;
   logic [NB-1:0]   ena_out;
   logic [NB*GW-1:0] amp_coef_out;

   int n_cmp = 0;
   int n_bad = 0;
   int done_cnt = 0;
   int d0;

   always #5 clk = ~clk;

   eq_band_gain_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sample_tick  (sample_tick),
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready),
      .cfg_band     (cfg_band),
      .cfg_gain     (cfg_gain),
      .cfg_ena      (cfg_ena),
      .commit       (commit),
      .busy         (busy),
      .done         (done),
      .ena_out      (ena_out),
      .amp_coef_out (amp_coef_out)
   );

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int gain_of(input int b);
      return int'(amp_coef_out[b*GW +: GW]);
   endfunction

   // Model: shadow/active per band; on commit, snapshot start and target,
   // then active value after r ramp ticks follows a closed form.
   int sg[NB], se[NB], ag[NB], ae[NB];
   int g0[NB], e0[NB], tg[NB], te[NB];
   bit m_busy, m_done;
   int m_ticks, m_steps;

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic int steps_of(input int b);
      if (te[b] != 0 && e0[b] == 0) return tg[b] + 1;
      if (te[b] == 0 && e0[b] != 0) return g0[b] + 1;
      if (te[b] != 0) return (tg[b] > g0[b]) ? tg[b] - g0[b] : g0[b] - tg[b];
      return 0;
   endfunction

   task automatic band_at(input int b, input int r, output int g, output int e);
      if (te[b] != 0 && e0[b] == 0) begin
         e = 1;
         g = imin(r - 1, tg[b]);
      end else if (te[b] == 0 && e0[b] != 0) begin
         g = imax(g0[b] - r, 0);
         e = (r > g0[b]) ? 0 : 1;
      end else if (te[b] != 0) begin
         e = 1;
         g = (tg[b] >= g0[b]) ? imin(g0[b] + r, tg[b]) : imax(g0[b] - r, tg[b]);
      end else begin
         e = 0;
         g = g0[b];
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      int r, g, e;
      if (!rst_n) begin
         for (int b = 0; b < NB; b++) begin
            sg[b] = 1; se[b] = 1; ag[b] = 1; ae[b] = 1;
         end
         m_busy = 0; m_done = 0; m_ticks = 0; m_steps = 0;
      end else begin
         m_done = 0;
         if (!m_busy) begin
            if (cfg_valid) begin
               sg[int'(cfg_band)] = int'(cfg_gain);
               se[int'(cfg_band)] = int'(cfg_ena);
            end
            if (commit) begin
               m_busy = 1; m_ticks = 0; m_steps = 0;
               for (int b = 0; b < NB; b++) begin
                  g0[b] = ag[b]; e0[b] = ae[b];
                  te[b] = se[b]; tg[b] = (se[b] != 0) ? sg[b] : 0;
                  m_steps = imax(m_steps, steps_of(b));
               end
            end
         end else if (sample_tick) begin
            m_ticks++;
            if (m_ticks >= 2) begin
               r = m_ticks - 1;
               for (int b = 0; b < NB; b++) begin
                  band_at(b, r, g, e);
                  ag[b] = g; ae[b] = e;
               end
               if (r == m_steps + 1) begin
                  m_busy = 0;
                  m_done = 1;
               end
            end
         end
      end
   end

   logic [NB-1:0]    xe;
   logic [NB*GW-1:0] xg;

   always @(negedge clk) begin
      for (int b = 0; b < NB; b++) begin
         xe[b] = (ae[b] != 0);
         xg[b*GW +: GW] = GW'(ag[b]);
      end
      chk("ena_out", 64'(ena_out), 64'(xe));
      chk("amp_coef_out", 64'(amp_coef_out), 64'(xg));
      chk("busy", 64'(busy), 64'(m_busy));
      chk("done", 64'(done), 64'(m_done));
      chk("cfg_ready", 64'(cfg_ready), 64'(!m_busy));
      if (done === 1'b1) done_cnt++;
   end

   task automatic do_tick();
      @(negedge clk);
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic wr(input int b, input int g, input bit e);
      @(negedge clk);
      cfg_valid = 1'b1;
      cfg_band  = 3'(b);
      cfg_gain  = GW'(g);
      cfg_ena   = e;
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   task automatic do_commit();
      @(negedge clk);
      commit = 1'b1;
      @(negedge clk);
      commit = 1'b0;
   endtask

   int up_exp[5] = '{1, 2, 3, 4, 5};

   initial begin
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);

      // reset state
      chk("rst ena", 64'(ena_out), 64'hFF);
      chk("rst gains", 64'(amp_coef_out), 64'o11111111);
      chk("rst ready", 64'(cfg_ready), 64'd1);
      chk("rst busy", 64'(busy), 64'd0);

      // band 3 ramp up
      wr(2, 5, 1'b1);
      chk("wr no active change", 64'(gain_of(2)), 64'd1);
      do_commit();
      chk("busy after commit", 64'(busy), 64'd1);
      d0 = done_cnt;
      for (int i = 0; i < 5; i++) begin
         do_tick();
         chk("up band3", 64'(gain_of(2)), 64'(up_exp[i]));
         chk("up band1", 64'(gain_of(0)), 64'd1);
      end
      chk("up no early done", 64'(done_cnt - d0), 64'd0);
      do_tick();
      chk("up done", 64'(done_cnt - d0), 64'd1);
      chk("up idle", 64'(busy), 64'd0);

      // disable band 7
      wr(6, 0, 1'b0);
      do_commit();
      d0 = done_cnt;
      do_tick();
      do_tick();
      chk("dis gain0", 64'(gain_of(6)), 64'd0);
      chk("dis ena still", 64'(ena_out[6]), 64'd1);
      do_tick();
      chk("dis ena off", 64'(ena_out[6]), 64'd0);
      chk("dis no done yet", 64'(done_cnt - d0), 64'd0);
      do_tick();
      chk("dis done", 64'(done_cnt - d0), 64'd1);

      // re-enable band 7
      wr(6, 7, 1'b1);
      do_commit();
      d0 = done_cnt;
      do_tick();
      do_tick();
      chk("ren ena on", 64'(ena_out[6]), 64'd1);
      chk("ren gain0", 64'(gain_of(6)), 64'd0);
      for (int i = 1; i <= 7; i++) begin
         do_tick();
         chk("ren step", 64'(gain_of(6)), 64'(i));
      end
      do_tick();
      chk("ren done", 64'(done_cnt - d0), 64'd1);
      chk("ren final", 64'(gain_of(6)), 64'd7);

      // handshake: writes and commit during RAMP
      wr(0, 3, 1'b1);
      do_commit();
      d0 = done_cnt;
      do_tick();
      @(negedge clk);
      cfg_valid = 1'b1; cfg_band = 3'd0; cfg_gain = 3'd6; cfg_ena = 1'b1;
      commit = 1'b1;
      @(negedge clk);
      commit = 1'b0;
      repeat (3) @(negedge clk);
      chk("ramp ready low", 64'(cfg_ready), 64'd0);
      do_tick();
      do_tick();
      cfg_valid = 1'b0;
      chk("hs band1", 64'(gain_of(0)), 64'd3);
      do_tick();
      do_tick();
      do_tick();
      chk("hs one done", 64'(done_cnt - d0), 64'd1);
      do_commit();
      d0 = done_cnt;
      do_tick();
      do_tick();
      chk("nodiff done", 64'(done_cnt - d0), 64'd1);
      chk("shadow kept", 64'(gain_of(0)), 64'd3);
      @(negedge clk);
      cfg_valid = 1'b1; cfg_band = 3'd4; cfg_gain = 3'd2; cfg_ena = 1'b1;
      commit = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0;
      commit = 1'b0;
      d0 = done_cnt;
      do_tick();
      do_tick();
      do_tick();
      chk("wr+commit gain", 64'(gain_of(4)), 64'd2);
      chk("wr+commit done", 64'(done_cnt - d0), 64'd1);

      // reset mid-ramp
      @(negedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b1;
      wr(2, 5, 1'b1);
      do_commit();
      d0 = done_cnt;
      do_tick();
      do_tick();
      chk("mr band3", 64'(gain_of(2)), 64'd2);
      @(negedge clk);
      #2;
      sample_tick = 1'b1;
      rst_n = 1'b0;
      #1;
      chk("mr ena", 64'(ena_out), 64'hFF);
      chk("mr gains", 64'(amp_coef_out), 64'o11111111);
      chk("mr busy", 64'(busy), 64'd0);
      chk("mr done", 64'(done), 64'd0);
      @(negedge clk);
      sample_tick = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("mr no done", 64'(done_cnt - d0), 64'd0);
      chk("mr ready", 64'(cfg_ready), 64'd1);
      do_tick();
      do_tick();
      chk("idle tick no effect", 64'(amp_coef_out), 64'o11111111);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
